// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a register slave.
// The master modport drives addresses, write data and the B/R READYs.
interface axi_lite_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: each accepted command becomes one AXI4-Lite
// write or read, and its data/response is returned on the result stream.
module axi_lite_cmd_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic                            busy,
  axi_lite_cmd_master_if.master           m_axi
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;
  localparam int CW = (C_TIMEOUT_CYCLES > 0) ? $clog2(C_TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (C_TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] TO_LIMIT = CW'(C_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            wait_to_q, wait_to_d;

  logic            aw_hs;
  logic            w_hs;
  logic            waiting;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;
    wait_to_d     = wait_to_q;

    aw_hs   = awvalid_q && m_axi.awready;
    w_hs    = wvalid_q && m_axi.wready;
    waiting = (state_q == WADDR) || (state_q == WRESP) ||
              (state_q == RADDR) || (state_q == RDATA);

    // Saturating wait counter; the flag sticks once the limit is reached so a
    // late response still reports the timeout without breaking the handshake.
    if (TO_EN && waiting && (wait_cnt_q != TO_LIMIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    if (TO_EN && waiting && (wait_cnt_d == TO_LIMIT)) begin
      wait_to_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
          wstrb_d    = cmd_wstrb;
          wait_cnt_d = '0;
          wait_to_d  = 1'b0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          if (cmd_write) begin
            state_d   = WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
          end
        end
      end

      WADDR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end
      end

      WRESP: begin
        if (bready_q && m_axi.bvalid) begin
          bready_d      = 1'b0;
          rsp_resp_d    = m_axi.bresp;
          rsp_rdata_d   = '0;
          rsp_timeout_d = wait_to_d;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end
      end

      RADDR: begin
        if (arvalid_q && m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end

      RDATA: begin
        if (rready_q && m_axi.rvalid) begin
          rready_d      = 1'b0;
          rsp_resp_d    = m_axi.rresp;
          rsp_rdata_d   = m_axi.rdata;
          rsp_timeout_d = wait_to_d;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready/busy are registered views of the next state, so cmd_ready only
    // rises once the result has been consumed and never overlaps RESP.
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
      wait_to_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
      wait_to_q     <= wait_to_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: a delay-configurable AXI4-Lite slave model
// on the bus and a scoreboard of expected results checked as each response appears.
module tb_axi_lite_cmd_master;

  logic        clk;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        busy;

  axi_lite_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi_lite_cmd_master #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .C_TIMEOUT_CYCLES(1024)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(aresetn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy),
    .m_axi        (axi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave behaviour knobs
  int          aw_delay, w_delay, b_delay, ar_delay, r_delay;
  logic [1:0]  b_resp_cfg, r_resp_cfg;
  int          b_count;
  logic [31:0] slv_mem [0:15];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [0:15];
  int          n_checks, n_fail;
  int          txn_id;
  int          lat, aw_cycles, w_cycles;

  // Slave model: everything happens on the falling edge. A handshake at a rising
  // edge is recognised one half-cycle later from the VALID seen at the previous
  // falling edge and the READY this model was driving.
  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic awv_s, wv_s, br_s, arv_s, rr_s;
    logic aw_got, w_got, b_pend, r_pend;
    logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
    logic [3:0]  w_strb_l;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    awv_s = 0; wv_s = 0; br_s = 0; arv_s = 0; rr_s = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    aw_addr_l = 0; w_data_l = 0; ar_addr_l = 0; w_strb_l = 0;
    b_count = 0;
    for (int i = 0; i < 16; i++) slv_mem[i] = 32'h0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 32'h0; axi.rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (aresetn !== 1'b1) begin
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        axi.arready = 0; axi.rvalid = 0;
      end else begin
        if (awv_s && axi.awready) begin aw_got = 1; aw_addr_l = axi.awaddr; aw_cnt = 0; end
        if (wv_s && axi.wready) begin
          w_got = 1; w_data_l = axi.wdata; w_strb_l = axi.wstrb; w_cnt = 0;
        end
        if (axi.bvalid && br_s) begin axi.bvalid = 0; b_count++; end
        if (arv_s && axi.arready) begin r_pend = 1; r_cnt = 0; ar_addr_l = axi.araddr; ar_cnt = 0; end
        if (axi.rvalid && rr_s) axi.rvalid = 0;
        if (aw_got && w_got) begin
          for (int i = 0; i < 4; i++)
            if (w_strb_l[i]) slv_mem[aw_addr_l[5:2]][8*i +: 8] = w_data_l[8*i +: 8];
          aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
        end
        axi.awready = axi.awvalid && !aw_got && (aw_cnt >= aw_delay);
        if (axi.awvalid && !aw_got && !axi.awready) aw_cnt++;
        axi.wready = axi.wvalid && !w_got && (w_cnt >= w_delay);
        if (axi.wvalid && !w_got && !axi.wready) w_cnt++;
        axi.arready = axi.arvalid && !r_pend && !axi.rvalid && (ar_cnt >= ar_delay);
        if (axi.arvalid && !r_pend && !axi.rvalid && !axi.arready) ar_cnt++;
        if (b_pend) begin
          if (b_cnt >= b_delay) begin axi.bvalid = 1; axi.bresp = b_resp_cfg; b_pend = 0; end
          else b_cnt++;
        end
        if (r_pend) begin
          if (r_cnt >= r_delay) begin
            axi.rvalid = 1; axi.rdata = slv_mem[ar_addr_l[5:2]]; axi.rresp = r_resp_cfg; r_pend = 0;
          end else r_cnt++;
        end
      end
      awv_s = axi.awvalid; wv_s = axi.wvalid; br_s = axi.bready;
      arv_s = axi.arvalid; rr_s = axi.rready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one command, wait for its acceptance and push the expected result.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [1:0] exp_resp, input logic exp_to);
    exp_t e;
    int   guard;
    e.wr = wr; e.addr = addr; e.resp = exp_resp; e.to = exp_to;
    if (wr) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) model_mem[addr[5:2]][8*i +: 8] = data[8*i +: 8];
      e.rdata = 32'h0;
    end else begin
      e.rdata = model_mem[addr[5:2]];
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_accept_wait", 32'(guard < 20), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    sb.push_back(e);
  endtask

  // Wait for the next result, compare it to the scoreboard head, then hold
  // rsp_ready low for 'hold' cycles before consuming it.
  task automatic wait_rsp(input int budget, input int hold);
    exp_t        e;
    logic [31:0] held;
    logic [1:0]  got_resp;
    logic        got_to;
    lat = 0; aw_cycles = 0; w_cycles = 0;
    while (rsp_valid !== 1'b1 && lat < budget) begin
      if (axi.awvalid === 1'b1) aw_cycles++;
      if (axi.wvalid === 1'b1) w_cycles++;
      @(negedge clk);
      lat++;
    end
    chk("rsp_within_budget", 32'(lat < budget), 32'd1);
    e = '{wr: 1'b0, addr: 32'h0, rdata: 32'h0, resp: 2'b00, to: 1'b0};
    if (sb.size() != 0) e = sb.pop_front();
    held = rsp_rdata; got_resp = rsp_resp; got_to = rsp_timeout;
    if (rsp_valid === 1'b1) begin
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("hold_rsp_rdata", rsp_rdata, held);
        chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_released", 32'(rsp_valid), 32'd0);
      chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
    end
    $display("txn %0d %s addr=0x%08h rdata=0x%08h resp=%0d timeout=%0d latency=%0d",
             txn_id, e.wr ? "WR" : "RD", e.addr, held, got_resp, got_to, lat);
    txn_id++;
  endtask

  initial begin
    logic [31:0] wd [3];
    logic [31:0] wa [3];
    int          b_before;
    int          guard;
    aresetn = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
    b_resp_cfg = 2'b00; r_resp_cfg = 2'b00;
    n_checks = 0; n_fail = 0; txn_id = 0;
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    wd[0] = 32'hABCD0001; wd[1] = 32'hDEAD0011; wd[2] = 32'hBEEF0011;
    wa[0] = 32'h4;        wa[1] = 32'h8;        wa[2] = 32'hC;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({cmd_ready, busy, rsp_valid, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}),
        32'd0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_release", 32'(cmd_ready), 32'd1);

    // Minimum-latency write to address 0
    issue(1'b1, 32'h0, 32'h0101FFFF, 4'hF, 2'b00, 1'b0);
    wait_rsp(50, 0);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_awvalid_cycles", 32'(aw_cycles), 32'd1);
    chk("wr_wvalid_cycles", 32'(w_cycles), 32'd1);
    chk("wr_b_count", 32'(b_count), 32'd1);

    // Write/read-back pairs
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, wa[i], wd[i], 4'hF, 2'b00, 1'b0);
      wait_rsp(50, 0);
      issue(1'b0, wa[i], 32'h0, 4'h0, 2'b00, 1'b0);
      wait_rsp(50, 0);
      chk("rd_latency", 32'(lat), 32'd2);
    end

    // AWREADY immediate, WREADY three cycles late, partial strobes
    w_delay = 3;
    b_before = b_count;
    issue(1'b1, 32'hC, 32'h11112222, 4'b0011, 2'b00, 1'b0);
    wait_rsp(50, 0);
    chk("split_awvalid_cycles", 32'(aw_cycles), 32'd1);
    chk("split_wvalid_cycles", 32'(w_cycles), 32'd4);
    chk("split_b_count", 32'(b_count - b_before), 32'd1);
    w_delay = 0;
    issue(1'b0, 32'hC, 32'h0, 4'h0, 2'b00, 1'b0);
    wait_rsp(50, 0);

    // Result held off by rsp_ready for 5 cycles
    issue(1'b0, 32'h4, 32'h0, 4'h0, 2'b00, 1'b0);
    wait_rsp(50, 5);

    // Slave error on read data is passed through
    r_resp_cfg = 2'b10;
    issue(1'b0, 32'h8, 32'h0, 4'h0, 2'b10, 1'b0);
    wait_rsp(50, 0);
    r_resp_cfg = 2'b00;

    // BVALID 1100 cycles late: timeout flagged, transaction still completes
    b_delay = 1100;
    issue(1'b1, 32'h14, 32'h5A5A0F0F, 4'hF, 2'b00, 1'b1);
    wait_rsp(1300, 0);
    chk("timeout_long_latency", 32'(lat >= 1100), 32'd1);
    b_delay = 0;
    issue(1'b1, 32'h10, 32'h00C0FFEE, 4'hF, 2'b00, 1'b0);
    wait_rsp(50, 0);

    // Reset while waiting in WRESP
    b_delay = 30;
    issue(1'b1, 32'h18, 32'hCAFEF00D, 4'hF, 2'b00, 1'b0);
    guard = 0;
    while (axi.bready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("reached_wresp", 32'(guard < 10), 32'd1);
    aresetn = 1'b0;
    @(negedge clk);
    chk("midtxn_reset_outputs",
        32'({cmd_ready, busy, rsp_valid, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}),
        32'd0);
    if (sb.size() != 0) void'(sb.pop_back());
    $display("txn %0d WR addr=0x00000018 abandoned by reset", txn_id);
    txn_id++;
    aresetn = 1'b1;
    b_delay = 0;
    @(negedge clk);
    chk("cmd_ready_after_midtxn_reset", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    chk("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    issue(1'b0, 32'h18, 32'h0, 4'h0, 2'b00, 1'b0);
    wait_rsp(50, 0);
    issue(1'b1, 32'h1C, 32'h76543210, 4'hF, 2'b00, 1'b0);
    wait_rsp(50, 0);
    issue(1'b0, 32'h1C, 32'h0, 4'h0, 2'b00, 1'b0);
    wait_rsp(50, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
